boot_load_ctrl: RTL and testbench

//  Boot/program-load sequencer between the board reset, the UART programmer core and the CPU datapath.

---
 rtl/boot_load_ctrl.sv | 131 +++++++++++++
 tb/tb_boot_load_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_load_ctrl.sv
// Boot/program-load sequencer: owns CPU run/hold and programmer reset, counts programmer writes.
// Optional macro UPG_TIMEOUT_EN adds an idle-timeout abort of a stalled LOAD.
module boot_load_ctrl #(
  parameter int ADDR_W         = 15,
  parameter int CNT_W          = 16,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 23_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_pg,
  input  logic              upg_wen_i,
  input  logic [ADDR_W-1:0] upg_adr_i,
  input  logic              upg_done_i,
  output logic              cpu_rst_n_o,
  output logic              upg_rst_o,
  output logic              loading_o,
  output logic [CNT_W-1:0]  word_cnt_o,
  output logic [ADDR_W-1:0] last_adr_o,
  output logic              timeout_o
);

  typedef enum logic [1:0] {S_HOLD, S_RUN, S_LOAD} state_t;

  localparam int HC_W = $clog2(HOLD_CYCLES + 1);

  if (HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("boot_load_ctrl: HOLD_CYCLES must be >=1 and TIMEOUT_CYCLES >=2");
  end

  state_t            r_state, w_next;
  logic [HC_W-1:0]   r_hold_cnt;
  logic              r_start_prev, r_wen_prev;
  logic              w_start_rise, w_wen_rise, w_timeout_hit;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_adr;
  logic              r_timeout;
  logic              r_cpu_rst_n, r_upg_rst, r_loading;

  assign w_start_rise = start_pg & ~r_start_prev;
  assign w_wen_rise   = upg_wen_i & ~r_wen_prev;

`ifdef UPG_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_idle;

  // Held at zero outside LOAD, so it is already clear on LOAD entry.
  always_ff @(posedge clk) begin
    if (!rst_n)                          r_idle <= '0;
    else if (r_state != S_LOAD || w_wen_rise) r_idle <= '0;
    else                                 r_idle <= r_idle + 1'b1;
  end

  // A done in the same cycle takes precedence, leaving timeout_o clear.
  assign w_timeout_hit = (r_state == S_LOAD) && !upg_done_i && !w_wen_rise &&
                         (r_idle == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_HOLD;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HOLD:  if (r_hold_cnt == HC_W'(HOLD_CYCLES - 1)) w_next = S_RUN;
      S_RUN:   if (w_start_rise)                         w_next = S_LOAD;
      S_LOAD:  if (upg_done_i || w_timeout_hit)          w_next = S_HOLD;
      default: w_next = S_HOLD;
    endcase
  end

  // Edge registers track every cycle so presses in HOLD/LOAD are never queued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_start_prev <= 1'b0;
      r_wen_prev   <= 1'b0;
    end else begin
      r_start_prev <= start_pg;
      r_wen_prev   <= upg_wen_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                 r_hold_cnt <= '0;
    else if (r_state != S_HOLD) r_hold_cnt <= '0;
    else                        r_hold_cnt <= r_hold_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_adr     <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == S_RUN && w_next == S_LOAD) begin
      r_cnt     <= '0;
      r_adr     <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == S_LOAD) begin
      if (w_wen_rise) begin
        if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
        r_adr <= upg_adr_i;
      end
      if (w_timeout_hit) r_timeout <= 1'b1;
    end
  end

  // Control outputs follow the registered state, one cycle behind it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cpu_rst_n <= 1'b0;
      r_upg_rst   <= 1'b1;
      r_loading   <= 1'b0;
    end else begin
      r_cpu_rst_n <= (r_state == S_RUN);
      r_upg_rst   <= (r_state != S_LOAD);
      r_loading   <= (r_state == S_LOAD);
    end
  end

  assign cpu_rst_n_o = r_cpu_rst_n;
  assign upg_rst_o   = r_upg_rst;
  assign loading_o   = r_loading;
  assign word_cnt_o  = r_cnt;
  assign last_adr_o  = r_adr;
  assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Self-checking bench for boot_load_ctrl: scoreboard of expected counter/address per write.
module tb_boot_load_ctrl;
  localparam int ADDR_W = 15;
  localparam int CNT_W  = 4;
  localparam int HOLD   = 4;
  localparam int TO     = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, start_pg, upg_wen_i, upg_done_i;
  logic [ADDR_W-1:0] upg_adr_i;
  logic              cpu_rst_n_o, upg_rst_o, loading_o, timeout_o;
  logic [CNT_W-1:0]  word_cnt_o;
  logic [ADDR_W-1:0] last_adr_o;

  boot_load_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start_pg(start_pg), .upg_wen_i(upg_wen_i),
    .upg_adr_i(upg_adr_i), .upg_done_i(upg_done_i), .cpu_rst_n_o(cpu_rst_n_o),
    .upg_rst_o(upg_rst_o), .loading_o(loading_o), .word_cnt_o(word_cnt_o),
    .last_adr_o(last_adr_o), .timeout_o(timeout_o)
  );

  typedef struct {
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] adr;
  } exp_t;

  exp_t              sb[$];
  int                checks = 0;
  int                failures = 0;
  logic [CNT_W-1:0]  m_cnt;
  logic [ADDR_W-1:0] m_adr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_run(output int n);
    n = 0;
    while (cpu_rst_n_o !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic enter_load();
    start_pg = 1'b1;
    tick();
    start_pg = 1'b0;
    tick();
    m_cnt = '0;
    m_adr = '0;
  endtask

  // Drive one wen pulse; expected counter/address go to the scoreboard and are popped after the counting edge.
  task automatic drive_write(input logic [ADDR_W-1:0] a, input logic with_done);
    exp_t e;
    upg_wen_i  = 1'b1;
    upg_adr_i  = a;
    upg_done_i = with_done;
    if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
    m_adr = a;
    sb.push_back('{cnt: m_cnt, adr: m_adr});
    tick();
    upg_wen_i  = 1'b0;
    upg_done_i = 1'b0;
    e = sb.pop_front();
    checks++;
    if (word_cnt_o !== e.cnt || last_adr_o !== e.adr) begin
      failures++;
      $display("FAIL write cnt/adr: got %0d/%h expected %0d/%h", word_cnt_o, last_adr_o, e.cnt, e.adr);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({cpu_rst_n_o, upg_rst_o, loading_o, timeout_o} !== 4'b0100 || word_cnt_o !== '0 || last_adr_o !== '0) begin
      failures++;
      $display("FAIL reset_state: cpu=%b upg=%b ld=%b to=%b cnt=%0d adr=%h expected 0 1 0 0 0 0",
               cpu_rst_n_o, upg_rst_o, loading_o, timeout_o, word_cnt_o, last_adr_o);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= HOLD; i++) begin
      tick();
      checks++;
      if (cpu_rst_n_o !== 1'b0 || upg_rst_o !== 1'b1) begin
        failures++;
        $display("FAIL hold_after_reset cycle %0d: cpu=%b upg=%b expected 0 1", i, cpu_rst_n_o, upg_rst_o);
      end
    end
    tick();
    checks++;
    if (cpu_rst_n_o !== 1'b1 || upg_rst_o !== 1'b1) begin
      failures++;
      $display("FAIL run_after_hold: cpu=%b upg=%b expected 1 1", cpu_rst_n_o, upg_rst_o);
    end
  endtask

  task automatic test_no_retrigger();
    int n, bad;
    start_pg = 1'b1;
    tick();
    tick();
    checks++;
    if (loading_o !== 1'b1 || upg_rst_o !== 1'b0 || cpu_rst_n_o !== 1'b0) begin
      failures++;
      $display("FAIL load_entry: ld=%b upg=%b cpu=%b expected 1 0 0", loading_o, upg_rst_o, cpu_rst_n_o);
    end
    for (int i = 0; i < 20; i++) tick();
    upg_done_i = 1'b1;
    tick();
    upg_done_i = 1'b0;
    wait_run(n);
    checks++;
    if (n != HOLD + 1) begin
      failures++;
      $display("FAIL hold_len_after_done: got %0d cycles expected %0d", n, HOLD + 1);
    end
    bad = 0;
    for (int i = 0; i < 27; i++) begin
      tick();
      if (loading_o !== 1'b0 || cpu_rst_n_o !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL held_start_retrigger: %0d bad cycles expected 0", bad);
    end
    start_pg = 1'b0;
    tick();
  endtask

  task automatic test_load_basic();
    int n;
    enter_load();
    checks++;
    if (loading_o !== 1'b1 || word_cnt_o !== '0 || last_adr_o !== '0) begin
      failures++;
      $display("FAIL load_clear: ld=%b cnt=%0d adr=%h expected 1 0 0", loading_o, word_cnt_o, last_adr_o);
    end
    for (int i = 0; i < 3; i++) drive_write(ADDR_W'(16 + i), 1'b0);
    upg_done_i = 1'b1;
    tick();
    upg_done_i = 1'b0;
    wait_run(n);
    checks++;
    if (n != HOLD + 1) begin
      failures++;
      $display("FAIL hold_len_basic: got %0d cycles expected %0d", n, HOLD + 1);
    end
    checks++;
    if (word_cnt_o !== 4'd3 || last_adr_o !== 15'h0012 || loading_o !== 1'b0) begin
      failures++;
      $display("FAIL retained_basic: cnt=%0d adr=%h ld=%b expected 3 0012 0", word_cnt_o, last_adr_o, loading_o);
    end
  endtask

  task automatic test_saturate();
    int n;
    enter_load();
    for (int i = 0; i < 19; i++) drive_write(ADDR_W'(256 + i), 1'b0);
    drive_write(15'h0200, 1'b1);
    checks++;
    if (word_cnt_o !== 4'hF || loading_o !== 1'b0) begin
      failures++;
      $display("FAIL saturate_done: cnt=%0d ld=%b expected 15 0", word_cnt_o, loading_o);
    end
    wait_run(n);
    checks++;
    if (n != HOLD) begin
      failures++;
      $display("FAIL hold_len_sat: got %0d cycles expected %0d", n, HOLD);
    end
  endtask

  task automatic test_timeout();
    int n;
    enter_load();
    drive_write(15'h0033, 1'b0);
`ifdef UPG_TIMEOUT_EN
    n = 1;
    while (timeout_o !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n != TO) begin
      failures++;
      $display("FAIL timeout_latency: got %0d cycles expected %0d", n, TO);
    end
    wait_run(n);
    checks++;
    if (timeout_o !== 1'b1 || word_cnt_o !== 4'd1 || cpu_rst_n_o !== 1'b1) begin
      failures++;
      $display("FAIL timeout_retained: to=%b cnt=%0d cpu=%b expected 1 1 1", timeout_o, word_cnt_o, cpu_rst_n_o);
    end
    enter_load();
    checks++;
    if (timeout_o !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear: got %b expected 0", timeout_o);
    end
`else
    for (int i = 0; i < 150; i++) tick();
    checks++;
    if (loading_o !== 1'b1 || timeout_o !== 1'b0) begin
      failures++;
      $display("FAIL no_timeout: ld=%b to=%b expected 1 0", loading_o, timeout_o);
    end
`endif
    upg_done_i = 1'b1;
    tick();
    upg_done_i = 1'b0;
    wait_run(n);
    checks++;
    if (cpu_rst_n_o !== 1'b1) begin
      failures++;
      $display("FAIL run_after_timeout_test: cpu=%b expected 1", cpu_rst_n_o);
    end
  endtask

  task automatic test_reset_mid_load();
    int n;
    enter_load();
    for (int i = 0; i < 5; i++) drive_write(ADDR_W'(64 + i), 1'b0);
    rst_n = 1'b0;
    tick();
    checks++;
    if (word_cnt_o !== '0 || last_adr_o !== '0 || upg_rst_o !== 1'b1 || cpu_rst_n_o !== 1'b0 || loading_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_load: cnt=%0d adr=%h upg=%b cpu=%b ld=%b expected 0 0 1 0 0",
               word_cnt_o, last_adr_o, upg_rst_o, cpu_rst_n_o, loading_o);
    end
    rst_n = 1'b1;
    wait_run(n);
    checks++;
    if (n != HOLD + 1) begin
      failures++;
      $display("FAIL hold_len_after_mid_reset: got %0d cycles expected %0d", n, HOLD + 1);
    end
  endtask

  initial begin
    rst_n = 1'b0; start_pg = 1'b0; upg_wen_i = 1'b0; upg_done_i = 1'b0; upg_adr_i = '0;
    m_cnt = '0; m_adr = '0;
    test_reset();
    test_no_retrigger();
    test_load_basic();
    test_saturate();
    test_timeout();
    test_reset_mid_load();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
